// File: rtl/rx_fifo_pkg.sv
// Shared constants for the USB receive FIFO.
// Default geometry and count-width derivation.
package rx_fifo_pkg;

  localparam int DEF_FIFO_DEPTH = 64;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int NUM_W          = 16;

  // One extra bit so the count can hold FIFO_DEPTH itself
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/rx_fifo_dpmem.sv
// Byte storage for the receive FIFO.
// One clocked write port, one asynchronous read port.
module rx_fifo_dpmem
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // Contents are never cleared; only pointers define validity
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo_buffer.sv
// Show-ahead receive FIFO between USB RX path and bus.
// Pointer/count control; storage lives in rx_fifo_dpmem.
module rx_fifo_buffer
  import rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic              busClk,
  input  logic              rstSyncToBusClk,
  input  logic [7:0]        dataIn,
  input  logic              fifoWEn,
  input  logic              fifoREn,
  input  logic              forceEmpty,
  output logic [7:0]        dataOut,
  output logic [NUM_W-1:0]  numElementsInFifo,
  output logic              fifoFull,
  output logic              fifoEmpty,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  wr_ok, rd_ok;
  logic                  mem_we;
  logic [7:0]            mem_rdata;

  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;

  // Acceptance: a flush swallows both strobes
  always_comb begin
    rd_ok  = fifoREn && !empty && !forceEmpty;
    wr_ok  = fifoWEn && (!full || fifoREn)
             && !forceEmpty;
    mem_we = wr_ok && !rstSyncToBusClk;
  end

  // Next pointer, count and error-pulse state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (forceEmpty) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = fifoWEn && !wr_ok;
      udf_d = fifoREn && empty;
    end
  end

  // Register control state; reset beats flush and strobes
  always_ff @(posedge busClk) begin
    if (rstSyncToBusClk) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  rx_fifo_dpmem #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_mem (
    .clk   (busClk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (dataIn),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign dataOut           = empty ? 8'h00 : mem_rdata;
  assign numElementsInFifo = NUM_W'(count_q);
  assign fifoFull          = full;
  assign fifoEmpty         = empty;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule

// File: tb/tb_rx_fifo_buffer.sv
// Self-checking bench for rx_fifo_buffer.
// Queue-based reference model, directed plus random stimulus.
module tb_rx_fifo_buffer;

  localparam int DEPTH = 64;

  logic        busClk = 1'b0;
  logic        rstSyncToBusClk;
  logic [7:0]  dataIn;
  logic        fifoWEn, fifoREn, forceEmpty;
  logic [7:0]  dataOut;
  logic [15:0] numElementsInFifo;
  logic        fifoFull, fifoEmpty, overflow, underflow;

  int tests  = 0;
  int failed = 0;

  byte unsigned q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  rx_fifo_buffer dut (
    .busClk            (busClk),
    .rstSyncToBusClk   (rstSyncToBusClk),
    .dataIn            (dataIn),
    .fifoWEn           (fifoWEn),
    .fifoREn           (fifoREn),
    .forceEmpty        (forceEmpty),
    .dataOut           (dataOut),
    .numElementsInFifo (numElementsInFifo),
    .fifoFull          (fifoFull),
    .fifoEmpty         (fifoEmpty),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  always #5 busClk = ~busClk;

  function automatic logic [27:0] exp_vec();
    logic [7:0] d;
    d = (q.size() > 0) ? q[0] : 8'h00;
    return {q.size() == DEPTH, q.size() == 0,
            16'(q.size()), d, m_ovf, m_udf};
  endfunction

  function automatic logic [27:0] obs_vec();
    return {fifoFull, fifoEmpty, numElementsInFifo,
            dataOut, overflow, underflow};
  endfunction

  // One clock: drive, sample head, clock, update model
  task automatic cyc(input logic w, input logic r,
                     input logic fe, input logic rst,
                     input logic [7:0] d,
                     output logic [7:0] got,
                     output logic [7:0] exp,
                     output logic popped);
    int sz;
    fifoWEn = w; fifoREn = r;
    forceEmpty = fe; rstSyncToBusClk = rst;
    dataIn = d;
    got = dataOut;
    exp = 8'h00;
    popped = 1'b0;
    @(posedge busClk); #1;
    sz = q.size();
    if (rst || fe) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      logic wok, rok;
      rok = r && sz > 0;
      wok = w && (sz < DEPTH || r);
      if (rok) begin
        exp = q.pop_front();
        popped = 1'b1;
      end
      if (wok) q.push_back(d);
      m_ovf = w && !wok;
      m_udf = r && sz == 0;
    end
    fifoWEn = 0; fifoREn = 0;
    forceEmpty = 0; rstSyncToBusClk = 0;
  endtask

  task automatic test_reset();
    logic [7:0] g, e;
    logic p;
    cyc(1, 1, 1, 1, 8'hEE, g, e, p);
    tests++;
    if (obs_vec() !== {1'b0, 1'b1, 16'd0, 8'h00, 2'b00}) begin
      failed++;
      $display("FAIL reset_state: got %h want %h",
               obs_vec(), {1'b0, 1'b1, 16'd0, 8'h00, 2'b00});
    end
  endtask

  task automatic test_basic();
    logic [7:0] g, e;
    logic p;
    logic [7:0] v [3];
    v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, v[i], g, e, p);
    tests++;
    if (numElementsInFifo !== 16'd3 || dataOut !== 8'h11) begin
      failed++;
      $display("FAIL basic_fill: got n=%0d d=%h want n=3 d=11",
               numElementsInFifo, dataOut);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 8'h00, g, e, p);
      tests++;
      if (g !== v[i]) begin
        failed++;
        $display("FAIL basic_read%0d: got %h want %h", i, g, v[i]);
      end
    end
    tests++;
    if (fifoEmpty !== 1'b1 || dataOut !== 8'h00) begin
      failed++;
      $display("FAIL basic_empty: got e=%b d=%h want e=1 d=00",
               fifoEmpty, dataOut);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] g, e;
    logic p;
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 0, 0, 0, 8'(i), g, e, p);
    tests++;
    if (fifoFull !== 1'b1 || numElementsInFifo !== 16'd64) begin
      failed++;
      $display("FAIL ovf_full: got f=%b n=%0d want f=1 n=64",
               fifoFull, numElementsInFifo);
    end
    cyc(1, 0, 0, 0, 8'hAA, g, e, p);
    tests++;
    if (overflow !== 1'b1 || numElementsInFifo !== 16'd64) begin
      failed++;
      $display("FAIL ovf_pulse: got o=%b n=%0d want o=1 n=64",
               overflow, numElementsInFifo);
    end
    cyc(0, 0, 0, 0, 8'h00, g, e, p);
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL ovf_one_cycle: got %b want 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 0, 8'h00, g, e, p);
      tests++;
      if (g !== 8'(i)) begin
        failed++;
        $display("FAIL ovf_drain%0d: got %h want %h", i, g, 8'(i));
      end
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] g, e;
    logic p;
    logic [7:0] want;
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 0, 0, 0, 8'(i), g, e, p);
    cyc(1, 1, 0, 0, 8'h55, g, e, p);
    tests++;
    if (g !== 8'h00 || numElementsInFifo !== 16'd64
        || overflow !== 1'b0) begin
      failed++;
      $display("FAIL full_rw: got d=%h n=%0d o=%b want 00 64 0",
               g, numElementsInFifo, overflow);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 1, 0, 0, 8'h00, g, e, p);
      want = (i == DEPTH) ? 8'h55 : 8'(i);
      tests++;
      if (g !== want) begin
        failed++;
        $display("FAIL full_rw_drain%0d: got %h want %h", i, g, want);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] g, e;
    logic p;
    cyc(0, 1, 0, 0, 8'h00, g, e, p);
    tests++;
    if (underflow !== 1'b1 || numElementsInFifo !== 16'd0) begin
      failed++;
      $display("FAIL udf_pulse: got u=%b n=%0d want u=1 n=0",
               underflow, numElementsInFifo);
    end
    cyc(0, 0, 0, 0, 8'h00, g, e, p);
    tests++;
    if (underflow !== 1'b0) begin
      failed++;
      $display("FAIL udf_one_cycle: got %b want 0", underflow);
    end
    cyc(1, 1, 0, 0, 8'h77, g, e, p);
    tests++;
    if (underflow !== 1'b1 || numElementsInFifo !== 16'd1
        || dataOut !== 8'h77) begin
      failed++;
      $display("FAIL udf_rw: got u=%b n=%0d d=%h want 1 1 77",
               underflow, numElementsInFifo, dataOut);
    end
    cyc(0, 1, 0, 0, 8'h00, g, e, p);
  endtask

  task automatic test_force_empty();
    logic [7:0] g, e;
    logic p;
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 0, 0, 8'($urandom), g, e, p);
    cyc(1, 0, 1, 0, 8'h99, g, e, p);
    tests++;
    if (numElementsInFifo !== 16'd0 || fifoEmpty !== 1'b1
        || overflow !== 1'b0 || dataOut !== 8'h00) begin
      failed++;
      $display("FAIL flush: got n=%0d e=%b o=%b d=%h want 0 1 0 00",
               numElementsInFifo, fifoEmpty, overflow, dataOut);
    end
    cyc(1, 0, 0, 0, 8'h42, g, e, p);
    cyc(0, 1, 0, 0, 8'h00, g, e, p);
    tests++;
    if (g !== 8'h42) begin
      failed++;
      $display("FAIL flush_after: got %h want 42", g);
    end
  endtask

  task automatic test_reset_midburst();
    logic [7:0] g, e;
    logic p;
    for (int i = 0; i < 7; i++)
      cyc(1, 0, 0, 0, 8'(8'hC0 + i), g, e, p);
    cyc(1, 1, 0, 1, 8'hFF, g, e, p);
    tests++;
    if (obs_vec() !== {1'b0, 1'b1, 16'd0, 8'h00, 2'b00}) begin
      failed++;
      $display("FAIL rst_mid: got %h want %h", obs_vec(),
               {1'b0, 1'b1, 16'd0, 8'h00, 2'b00});
    end
    cyc(1, 0, 0, 0, 8'h5A, g, e, p);
    tests++;
    if (dataOut !== 8'h5A || numElementsInFifo !== 16'd1) begin
      failed++;
      $display("FAIL rst_mid_write: got d=%h n=%0d want 5a 1",
               dataOut, numElementsInFifo);
    end
    cyc(0, 1, 0, 0, 8'h00, g, e, p);
  endtask

  task automatic test_wrap();
    logic [7:0] g, e;
    logic p, w, r;
    int sz;
    while (q.size() < 56)
      cyc(1, 0, 0, 0, 8'($urandom), g, e, p);
    for (int i = 0; i < 1000; i++) begin
      sz = q.size();
      if (sz <= 50) begin
        w = 1'b1; r = 1'($urandom);
      end else if (sz >= 63) begin
        r = 1'b1; w = 1'($urandom);
      end else begin
        w = 1'($urandom); r = 1'($urandom);
      end
      cyc(w, r, 0, 0, 8'($urandom), g, e, p);
      if (p) begin
        tests++;
        if (g !== e) begin
          failed++;
          $display("FAIL wrap_data@%0d: got %h want %h", i, g, e);
        end
      end
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL wrap_state@%0d: got %h want %h",
                 i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random_mix();
    logic [7:0] g, e;
    logic p, w, r, fe;
    for (int i = 0; i < 1200; i++) begin
      if (i < 600) begin
        w = ($urandom % 4) != 0;
        r = ($urandom % 3) == 0;
      end else begin
        w = ($urandom % 3) == 0;
        r = ($urandom % 4) != 0;
      end
      fe = ($urandom % 40) == 0;
      cyc(w, r, fe, 0, 8'($urandom), g, e, p);
      if (p) begin
        tests++;
        if (g !== e) begin
          failed++;
          $display("FAIL mix_data@%0d: got %h want %h", i, g, e);
        end
      end
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL mix_state@%0d: got %h want %h",
                 i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rstSyncToBusClk = 1'b1;
    dataIn = 8'h00;
    fifoWEn = 1'b0;
    fifoREn = 1'b0;
    forceEmpty = 1'b0;
    @(posedge busClk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_force_empty();
    test_reset_midburst();
    test_wrap();
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
